// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package im_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_RESP   = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam logic [7:0] MAGIC     = 8'h55;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;
  localparam int         LEN_W     = 16;
  localparam logic [1:0] LAST_BYTE = 2'd3;

  // States in which the inter-byte idle timer runs.
  function automatic logic is_frame_state(input state_e s);
    case (s)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/im_loader_word_assembler.sv
// Packs big-endian bytes into 32-bit words; word_ready flags the byte that completes a word.
module word_assembler
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  // Next shift-register contents and byte position
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr) begin
      shift_d = 24'd0;
      cnt_d   = 2'd0;
    end else if (byte_valid) begin
      shift_d = {shift_q[15:0], byte_data};
      cnt_d   = cnt_q + 2'd1;
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  assign word       = {shift_q, byte_data};
  assign word_ready = byte_valid && !clr && (cnt_q == LAST_BYTE);

  // Shift register and byte counter flops
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= 24'd0;
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Boot loader: frames the UART byte stream, writes words into IM from word 0,
// verifies an XOR checksum, answers ACK/NAK and releases the CPU on success.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int IM_ADDR_W      = 11,
  parameter int IM_WORDS       = 2048,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Rx_Valid,
  input  logic [7:0]           Rx_Data,
  output logic                 IM_We,
  output logic [IM_ADDR_W-1:0] IM_Addr,
  output logic [31:0]          IM_Din,
  output logic                 Ack_Valid,
  output logic [7:0]           Ack_Data,
  input  logic                 Ack_Ready,
  output logic                 CPU_Hold,
  output logic                 Load_Done,
  output logic                 Load_Error
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W:0]   MAX_LEN  = (LEN_W + 1)'(IM_WORDS);

  state_e               state_q, state_d;
  logic [7:0]           len_hi_q, len_hi_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     word_idx_q, word_idx_d;
  logic [7:0]           chk_q, chk_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 im_we_q, im_we_d;
  logic [IM_ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]          im_din_q, im_din_d;
  logic                 ack_valid_q, ack_valid_d;
  logic [7:0]           ack_data_q, ack_data_d;
  logic                 cpu_hold_q, cpu_hold_d;
  logic                 load_done_q, load_done_d;
  logic                 load_error_q, load_error_d;

  logic [LEN_W-1:0]     len_rx_s;
  logic                 over_len_s;
  logic                 timeout_s;
  logic                 last_word_s;
  logic                 handshake_s;
  logic                 ack_pass_s;
  logic                 asm_clr_s;
  logic                 asm_valid_s;
  logic                 asm_ready_s;
  logic [31:0]          asm_word_s;

  assign len_rx_s    = {len_hi_q, Rx_Data};
  assign over_len_s  = {1'b0, len_rx_s} > MAX_LEN;
  assign timeout_s   = is_frame_state(state_q) && !Rx_Valid && (tmo_q == TMO_LAST);
  assign last_word_s = word_idx_q == (len_q - LEN_W'(1));
  assign handshake_s = ack_valid_q && Ack_Ready;
  assign ack_pass_s  = (state_q == S_CHECK) && Rx_Valid && (Rx_Data == chk_q);
  assign asm_clr_s   = (state_q == S_IDLE) || (state_q == S_LEN_LO);
  assign asm_valid_s = Rx_Valid && (state_q == S_DATA);

  word_assembler u_word_assembler (
    .clk        (Clock),
    .rst        (Reset),
    .clr        (asm_clr_s),
    .byte_valid (asm_valid_s),
    .byte_data  (Rx_Data),
    .word       (asm_word_s),
    .word_ready (asm_ready_s)
  );

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Rx_Valid && (Rx_Data == MAGIC)) state_d = S_LEN_HI;
        else                                state_d = S_IDLE;
      end
      S_LEN_HI: begin
        if (Rx_Valid)       state_d = S_LEN_LO;
        else if (timeout_s) state_d = S_RESP;
        else                state_d = S_LEN_HI;
      end
      S_LEN_LO: begin
        if (Rx_Valid) begin
          if (over_len_s)                   state_d = S_RESP;
          else if (len_rx_s == LEN_W'(0))   state_d = S_CHECK;
          else                              state_d = S_DATA;
        end else if (timeout_s) begin
          state_d = S_RESP;
        end else begin
          state_d = S_LEN_LO;
        end
      end
      S_DATA: begin
        if (asm_ready_s && last_word_s) state_d = S_CHECK;
        else if (timeout_s)             state_d = S_RESP;
        else                            state_d = S_DATA;
      end
      S_CHECK: begin
        if (Rx_Valid || timeout_s) state_d = S_RESP;
        else                       state_d = S_CHECK;
      end
      S_RESP: begin
        if (handshake_s) state_d = (ack_data_q == ACK) ? S_DONE : S_IDLE;
        else             state_d = S_RESP;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    chk_d        = chk_q;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_din_d     = im_din_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;

    case (state_q)
      S_IDLE: begin
        if (Rx_Valid && (Rx_Data == MAGIC)) load_error_d = 1'b0;
        else                                load_error_d = load_error_q;
      end
      S_LEN_HI: begin
        if (Rx_Valid) len_hi_d = Rx_Data;
        else          len_hi_d = len_hi_q;
      end
      S_LEN_LO: begin
        if (Rx_Valid) begin
          len_d      = len_rx_s;
          word_idx_d = {LEN_W{1'b0}};
          chk_d      = 8'h00;
        end else begin
          len_d      = len_q;
        end
      end
      S_DATA: begin
        if (Rx_Valid) chk_d = chk_q ^ Rx_Data;
        else          chk_d = chk_q;
        if (asm_ready_s) begin
          im_we_d    = 1'b1;
          im_addr_d  = word_idx_q[IM_ADDR_W-1:0];
          im_din_d   = asm_word_s;
          word_idx_d = word_idx_q + LEN_W'(1);
        end else begin
          im_we_d    = 1'b0;
        end
      end
      S_RESP: begin
        if (handshake_s && (ack_data_q == ACK)) begin
          load_done_d = 1'b1;
          cpu_hold_d  = 1'b0;
        end else if (handshake_s) begin
          load_error_d = 1'b1;
        end else begin
          load_done_d  = load_done_q;
        end
      end
      default: im_we_d = 1'b0;
    endcase

    // The response byte is decided on the cycle that enters RESP
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      ack_valid_d = 1'b1;
      ack_data_d  = ack_pass_s ? ACK : NAK;
    end else if ((state_q == S_RESP) && handshake_s) begin
      ack_valid_d = 1'b0;
      ack_data_d  = ack_data_q;
    end else begin
      ack_valid_d = ack_valid_q;
      ack_data_d  = ack_data_q;
    end

    if (!is_frame_state(state_q) || Rx_Valid || (state_d != state_q)) tmo_d = {TMO_W{1'b0}};
    else                                                               tmo_d = tmo_q + TMO_W'(1);
  end

  // Datapath and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      len_hi_q     <= 8'h00;
      len_q        <= {LEN_W{1'b0}};
      word_idx_q   <= {LEN_W{1'b0}};
      chk_q        <= 8'h00;
      tmo_q        <= {TMO_W{1'b0}};
      im_we_q      <= 1'b0;
      im_addr_q    <= {IM_ADDR_W{1'b0}};
      im_din_q     <= 32'd0;
      ack_valid_q  <= 1'b0;
      ack_data_q   <= 8'h00;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      chk_q        <= chk_d;
      tmo_q        <= tmo_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_din_q     <= im_din_d;
      ack_valid_q  <= ack_valid_d;
      ack_data_q   <= ack_data_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign IM_We      = im_we_q;
  assign IM_Addr    = im_addr_q;
  assign IM_Din     = im_din_q;
  assign Ack_Valid  = ack_valid_q;
  assign Ack_Data   = ack_data_q;
  assign CPU_Hold   = cpu_hold_q;
  assign Load_Done  = load_done_q;
  assign Load_Error = load_error_q;

endmodule

// File: tb/tb_im_loader.sv
// Scenario bench for im_loader with a frame-level reference model (TIMEOUT_CYCLES=16).
module tb_im_loader;

  localparam int AW = 11;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Rx_Valid = 1'b0;
  logic [7:0]    Rx_Data = 8'h00;
  logic          Ack_Ready = 1'b0;
  logic          IM_We;
  logic [AW-1:0] IM_Addr;
  logic [31:0]   IM_Din;
  logic          Ack_Valid;
  logic [7:0]    Ack_Data;
  logic          CPU_Hold;
  logic          Load_Done;
  logic          Load_Error;

  always #5 Clock = ~Clock;

  im_loader #(.IM_ADDR_W(AW), .IM_WORDS(2048), .TIMEOUT_CYCLES(16)) dut (
    .Clock(Clock), .Reset(Reset), .Rx_Valid(Rx_Valid), .Rx_Data(Rx_Data),
    .IM_We(IM_We), .IM_Addr(IM_Addr), .IM_Din(IM_Din),
    .Ack_Valid(Ack_Valid), .Ack_Data(Ack_Data), .Ack_Ready(Ack_Ready),
    .CPU_Hold(CPU_Hold), .Load_Done(Load_Done), .Load_Error(Load_Error)
  );

  int            n_checks = 0;
  int            n_fail = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  logic [7:0]    frame_q[$];
  logic [7:0]    exp_ack;
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  bit            got;

  // Write monitor: every IM_We cycle is one recorded write
  always @(negedge Clock) begin
    if (IM_We === 1'b1) begin
      wr_addr_q.push_back(IM_Addr);
      wr_data_q.push_back(IM_Din);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Frame-level model: decode the frame bytes into expected writes and response.
  function automatic void model_frame();
    int len;
    logic [7:0] x;
    exp_addr_q.delete();
    exp_data_q.delete();
    len = int'({frame_q[1], frame_q[2]});
    if (len > 2048) begin
      exp_ack = 8'h15;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < len; w++) begin
      exp_addr_q.push_back(AW'(w));
      exp_data_q.push_back({frame_q[3+4*w], frame_q[4+4*w], frame_q[5+4*w], frame_q[6+4*w]});
      for (int b = 0; b < 4; b++) x = x ^ frame_q[3+4*w+b];
    end
    exp_ack = (x == frame_q[3+4*len]) ? 8'h06 : 8'h15;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    Rx_Valid = 1'b1;
    Rx_Data  = b;
    @(negedge Clock);
    Rx_Valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frame_q[i]) begin
      send_byte(frame_q[i]);
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge Clock);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Rx_Valid = 1'b0;
    Ack_Ready = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic wait_ack(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (Ack_Valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge Clock);
    end
  endtask

  task automatic handshake(input int delay);
    Ack_Ready = 1'b0;
    repeat (delay) @(negedge Clock);
    Ack_Ready = 1'b1;
    @(negedge Clock);
    Ack_Ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clock);
    do_reset();
    n_checks++;
    if ({IM_We, IM_Addr, IM_Din} !== {1'b0, 11'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_im: got we=%b addr=%h din=%h want 0/0/0", IM_We, IM_Addr, IM_Din);
    end
    n_checks++;
    if ({Ack_Valid, Ack_Data} !== {1'b0, 8'h00}) begin
      n_fail++; $display("FAIL reset_ack: got valid=%b data=%h want 0/00", Ack_Valid, Ack_Data);
    end
    n_checks++;
    if ({CPU_Hold, Load_Done, Load_Error} !== 3'b100) begin
      n_fail++; $display("FAIL reset_status: got hold/done/err=%b want 100", {CPU_Hold, Load_Done, Load_Error});
    end
  endtask

  task automatic test_one_word();
    do_reset();
    frame_q = {8'h55, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE};
    send_frame(0);
    n_checks++;
    if (IM_We !== 1'b0) begin n_fail++; $display("FAIL one_pre_we: got %b want 0", IM_We); end
    send_byte(8'hEF);
    n_checks++;
    if ({IM_We, IM_Addr, IM_Din} !== {1'b1, 11'd0, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL one_write: got we=%b addr=%h din=%h want 1/000/deadbeef", IM_We, IM_Addr, IM_Din);
    end
    send_byte(8'h22);
    n_checks++;
    if ({IM_We, Ack_Valid, Ack_Data} !== {1'b0, 1'b1, 8'h06}) begin
      n_fail++; $display("FAIL one_ack: got we=%b valid=%b data=%h want 0/1/06", IM_We, Ack_Valid, Ack_Data);
    end
    handshake(0);
    n_checks++;
    if ({Ack_Valid, Load_Done, CPU_Hold, Load_Error} !== 4'b0100) begin
      n_fail++; $display("FAIL one_done: got valid/done/hold/err=%b want 0100", {Ack_Valid, Load_Done, CPU_Hold, Load_Error});
    end
    frame_q = {8'h55, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_frame(0);
    repeat (3) @(negedge Clock);
    n_checks++;
    if ({wr_addr_q.size() == 1, Ack_Valid, Load_Done} !== 3'b101) begin
      n_fail++; $display("FAIL done_ignores: got writes=%0d valid=%b done=%b want 1/0/1", wr_addr_q.size(), Ack_Valid, Load_Done);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    frame_q = {8'h55, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03};
    model_frame();
    send_frame(0);
    n_checks++;
    if ({Ack_Valid, Ack_Data} !== {1'b1, exp_ack}) begin
      n_fail++; $display("FAIL b2b_ack: got valid=%b data=%h want 1/%h", Ack_Valid, Ack_Data, exp_ack);
    end
    handshake(2);
    n_checks++;
    if (wr_addr_q.size() !== exp_addr_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d writes want %0d", wr_addr_q.size(), exp_addr_q.size());
    end else begin
      foreach (exp_addr_q[i]) begin
        n_checks++;
        if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr_q[i], exp_data_q[i]}) begin
          n_fail++; $display("FAIL b2b_write%0d: got %h:%h want %h:%h", i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
        end
      end
    end
    n_checks++;
    if ({Load_Done, CPU_Hold} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_done: got done/hold=%b want 10", {Load_Done, CPU_Hold});
    end
  endtask

  task automatic test_chk_mismatch();
    do_reset();
    frame_q = {8'h55, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    send_frame(0);
    n_checks++;
    if ({Ack_Valid, Ack_Data} !== {1'b1, 8'h15}) begin
      n_fail++; $display("FAIL bad_chk_nak: got valid=%b data=%h want 1/15", Ack_Valid, Ack_Data);
    end
    handshake(1);
    n_checks++;
    if ({Load_Error, CPU_Hold, Load_Done} !== 3'b110) begin
      n_fail++; $display("FAIL bad_chk_status: got err/hold/done=%b want 110", {Load_Error, CPU_Hold, Load_Done});
    end
    send_byte(8'h55);
    n_checks++;
    if (Load_Error !== 1'b0) begin n_fail++; $display("FAIL retry_clear_err: got %b want 0", Load_Error); end
    frame_q = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_frame(0);
    n_checks++;
    if ({Ack_Valid, Ack_Data} !== {1'b1, 8'h06}) begin
      n_fail++; $display("FAIL retry_ack: got valid=%b data=%h want 1/06", Ack_Valid, Ack_Data);
    end
    handshake(0);
    n_checks++;
    if ({Load_Done, CPU_Hold, Load_Error, wr_addr_q.size() == 2} !== 4'b1001) begin
      n_fail++; $display("FAIL retry_done: got done/hold/err=%b writes=%0d want 100/2", {Load_Done, CPU_Hold, Load_Error}, wr_addr_q.size());
    end
  endtask

  task automatic test_length_bounds();
    do_reset();
    frame_q = {8'h55, 8'h08, 8'h01};
    send_frame(0);
    n_checks++;
    if ({Ack_Valid, Ack_Data} !== {1'b1, 8'h15}) begin
      n_fail++; $display("FAIL overlen_nak: got valid=%b data=%h want 1/15", Ack_Valid, Ack_Data);
    end
    handshake(0);
    repeat (2) @(negedge Clock);
    n_checks++;
    if ({wr_addr_q.size() == 0, Load_Error} !== 2'b11) begin
      n_fail++; $display("FAIL overlen_nowrite: got writes=%0d err=%b want 0/1", wr_addr_q.size(), Load_Error);
    end
    frame_q = {8'h55, 8'h00, 8'h00, 8'h01};
    send_frame(1);
    wait_ack(got);
    n_checks++;
    if ({got, Ack_Data} !== {1'b1, 8'h15}) begin
      n_fail++; $display("FAIL len0_bad: got seen=%b data=%h want 1/15", got, Ack_Data);
    end
    handshake(0);
    frame_q = {8'h55, 8'h00, 8'h00, 8'h00};
    send_frame(1);
    wait_ack(got);
    n_checks++;
    if ({got, Ack_Data} !== {1'b1, 8'h06}) begin
      n_fail++; $display("FAIL len0_ok: got seen=%b data=%h want 1/06", got, Ack_Data);
    end
    handshake(0);
    n_checks++;
    if ({Load_Done, CPU_Hold, wr_addr_q.size() == 0} !== 3'b101) begin
      n_fail++; $display("FAIL len0_done: got done/hold=%b writes=%0d want 10/0", {Load_Done, CPU_Hold}, wr_addr_q.size());
    end
  endtask

  task automatic test_timeout_backpressure();
    do_reset();
    frame_q = {8'h55, 8'h00, 8'h01, 8'hDE, 8'hAD};
    send_frame(0);
    repeat (15) @(negedge Clock);
    n_checks++;
    if (Ack_Valid !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got valid=%b want 0 after 15 idle", Ack_Valid); end
    @(negedge Clock);
    n_checks++;
    if ({Ack_Valid, Ack_Data} !== {1'b1, 8'h15}) begin
      n_fail++; $display("FAIL tmo_nak: got valid=%b data=%h want 1/15 after 16 idle", Ack_Valid, Ack_Data);
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 2) send_byte(8'h55);
      else        @(negedge Clock);
      n_checks++;
      if ({Ack_Valid, Ack_Data} !== {1'b1, 8'h15}) begin
        n_fail++; $display("FAIL hold_stable%0d: got valid=%b data=%h want 1/15", k, Ack_Valid, Ack_Data);
      end
    end
    handshake(0);
    n_checks++;
    if ({Ack_Valid, Load_Error, CPU_Hold} !== 3'b011) begin
      n_fail++; $display("FAIL tmo_status: got valid/err/hold=%b want 011", {Ack_Valid, Load_Error, CPU_Hold});
    end
    frame_q = {8'h55, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_frame(2);
    wait_ack(got);
    n_checks++;
    if ({got, Ack_Data} !== {1'b1, 8'h06}) begin
      n_fail++; $display("FAIL tmo_retry: got seen=%b data=%h want 1/06", got, Ack_Data);
    end
    handshake(0);
  endtask

  task automatic test_reset_mid_data();
    do_reset();
    frame_q = {8'h55, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(0);
    Reset = 1'b1;
    @(negedge Clock);
    n_checks++;
    if ({IM_We, Ack_Valid, CPU_Hold, Load_Done, Load_Error} !== 5'b00100) begin
      n_fail++; $display("FAIL midreset_out: got we/valid/hold/done/err=%b want 00100", {IM_We, Ack_Valid, CPU_Hold, Load_Done, Load_Error});
    end
    Reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    repeat (20) @(negedge Clock);
    n_checks++;
    if ({wr_addr_q.size() == 0, Ack_Valid} !== 2'b10) begin
      n_fail++; $display("FAIL midreset_quiet: got writes=%0d valid=%b want 0/0", wr_addr_q.size(), Ack_Valid);
    end
    frame_q = {8'h55, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30};
    send_frame(1);
    wait_ack(got);
    n_checks++;
    if ({got, Ack_Data} !== {1'b1, 8'h06}) begin
      n_fail++; $display("FAIL midreset_reload: got seen=%b data=%h want 1/06", got, Ack_Data);
    end
    handshake(0);
    n_checks++;
    if ({wr_addr_q.size() == 1, Load_Done} !== 2'b11 || wr_data_q[0] !== 32'hCAFEBABE || wr_addr_q[0] !== 11'd0) begin
      n_fail++; $display("FAIL midreset_write: got writes=%0d done=%b want 1 write cafebabe@0 done=1", wr_addr_q.size(), Load_Done);
    end
    Reset = 1'b1;
    @(negedge Clock);
    n_checks++;
    if ({CPU_Hold, Load_Done, Load_Error, Ack_Valid} !== 4'b1000) begin
      n_fail++; $display("FAIL donereset: got hold/done/err/valid=%b want 1000", {CPU_Hold, Load_Done, Load_Error, Ack_Valid});
    end
    Reset = 1'b0;
  endtask

  task automatic test_random();
    int len;
    logic [7:0] x, b;
    for (int it = 0; it < 10; it++) begin
      do_reset();
      len = (it % 4 == 3) ? int'($urandom_range(65535, 2049)) : int'($urandom_range(6, 1));
      frame_q = {8'h55, 8'(len >> 8), 8'(len)};
      if (len <= 2048) begin
        x = 8'h00;
        for (int i = 0; i < 4 * len; i++) begin
          b = 8'($urandom);
          frame_q.push_back(b);
          x = x ^ b;
        end
        if ($urandom_range(3, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
        frame_q.push_back(x);
      end
      model_frame();
      send_frame(3);
      wait_ack(got);
      n_checks++;
      if ({got, Ack_Data} !== {1'b1, exp_ack}) begin
        n_fail++; $display("FAIL rand%0d_ack: got seen=%b data=%h want 1/%h", it, got, Ack_Data, exp_ack);
      end
      handshake(int'($urandom_range(3, 0)));
      repeat (2) @(negedge Clock);
      n_checks++;
      if (wr_addr_q.size() !== exp_addr_q.size()) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d writes want %0d", it, wr_addr_q.size(), exp_addr_q.size());
      end else begin
        foreach (exp_addr_q[i]) begin
          n_checks++;
          if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr_q[i], exp_data_q[i]}) begin
            n_fail++; $display("FAIL rand%0d_write%0d: got %h:%h want %h:%h", it, i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
          end
        end
      end
      n_checks++;
      if ({Load_Done, Load_Error, CPU_Hold} !== ((exp_ack == 8'h06) ? 3'b100 : 3'b011)) begin
        n_fail++; $display("FAIL rand%0d_status: got done/err/hold=%b for response %h", it, {Load_Done, Load_Error, CPU_Hold}, exp_ack);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_back_to_back();
    test_chk_mismatch();
    test_length_bounds();
    test_timeout_backpressure();
    test_reset_mid_data();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
